// File: rtl/fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer_pkg
// Description : Shared fetch-packet type and fetch width for the front end.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_buffer_pkg;

    localparam int FETCH_WIDTH = 4;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0][31:0] instr;
        logic [FETCH_WIDTH-1:0]       instr_valid;
        logic [31:0]                  start_pc;
        logic                         pred_taken;
        logic [1:0]                   pred_cut_pos;
        logic [31:0]                  pred_target;
    } fetch_packet_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Packet-granular instruction queue between IFU and decoder.
//               Optional same-cycle bypass when empty: FETCH_BUFFER_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FETCH_WIDTH-1:0][31:0] in_instr,
    input  logic [FETCH_WIDTH-1:0]       in_instr_valid,
    input  logic [31:0]                  in_start_pc,
    input  logic                         in_pred_taken,
    input  logic [1:0]                   in_pred_cut_pos,
    input  logic [31:0]                  in_pred_target,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [FETCH_WIDTH-1:0][31:0] out_instr,
    output logic [FETCH_WIDTH-1:0]       out_instr_valid,
    output logic [31:0]                  out_start_pc,
    output logic                         out_pred_taken,
    output logic [1:0]                   out_pred_cut_pos,
    output logic [31:0]                  out_pred_target,
    output logic [PTR_W:0]               occupancy
);

    localparam logic [PTR_W:0] c_PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    fetch_packet_t  r_mem [DEPTH];
    logic [PTR_W:0] r_head;
    logic [PTR_W:0] r_tail;

    fetch_packet_t  w_in_pkt;
    fetch_packet_t  w_head_pkt;
    fetch_packet_t  w_out_pkt;
    logic           w_full;
    logic           w_empty;
    logic           w_in_nonzero;
    logic           w_bypass;
    logic           w_push;
    logic           w_pop;

    assign w_in_pkt.instr        = in_instr;
    assign w_in_pkt.instr_valid  = in_instr_valid;
    assign w_in_pkt.start_pc     = in_start_pc;
    assign w_in_pkt.pred_taken   = in_pred_taken;
    assign w_in_pkt.pred_cut_pos = in_pred_cut_pos;
    assign w_in_pkt.pred_target  = in_pred_target;

    // Wrap bit distinguishes full from empty when the indices coincide.
    assign w_full  = (r_head[PTR_W-1:0] == r_tail[PTR_W-1:0]) && (r_head[PTR_W] != r_tail[PTR_W]);
    assign w_empty = (r_head == r_tail);

    assign in_ready     = !w_full;
    assign occupancy    = r_tail - r_head;
    assign w_in_nonzero = |in_instr_valid;
    assign w_head_pkt   = r_mem[r_head[PTR_W-1:0]];
    assign w_pop        = !w_empty && out_ready;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign w_bypass  = w_empty && in_valid && w_in_nonzero;
    assign w_out_pkt = w_bypass ? w_in_pkt : w_head_pkt;
    assign out_valid = !w_empty || (w_bypass && !flush);
    // A bypassed packet taken by the decoder never occupies an entry.
    assign w_push    = in_valid && in_ready && w_in_nonzero && !(w_bypass && out_ready);
`else
    assign w_bypass  = 1'b0;
    assign w_out_pkt = w_head_pkt;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready && w_in_nonzero;
`endif

    assign out_instr        = w_out_pkt.instr;
    assign out_instr_valid  = (w_empty && !w_bypass) ? '0 : w_out_pkt.instr_valid;
    assign out_start_pc     = w_out_pkt.start_pc;
    assign out_pred_taken   = w_out_pkt.pred_taken;
    assign out_pred_cut_pos = w_out_pkt.pred_cut_pos;
    assign out_pred_target  = w_out_pkt.pred_target;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
        end
    end

    // Storage is left uncleared on reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_mem[r_tail[PTR_W-1:0]] <= w_in_pkt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Scoreboard bench for fetch_buffer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [FETCH_WIDTH-1:0][31:0] in_instr;
    logic [FETCH_WIDTH-1:0]       in_instr_valid;
    logic [31:0]                  in_start_pc;
    logic                         in_pred_taken;
    logic [1:0]                   in_pred_cut_pos;
    logic [31:0]                  in_pred_target;
    logic                         out_valid;
    logic                         out_ready;
    logic [FETCH_WIDTH-1:0][31:0] out_instr;
    logic [FETCH_WIDTH-1:0]       out_instr_valid;
    logic [31:0]                  out_start_pc;
    logic                         out_pred_taken;
    logic [1:0]                   out_pred_cut_pos;
    logic [31:0]                  out_pred_target;
    logic [PTR_W:0]               occupancy;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_instr_valid(in_instr_valid), .in_start_pc(in_start_pc),
        .in_pred_taken(in_pred_taken), .in_pred_cut_pos(in_pred_cut_pos),
        .in_pred_target(in_pred_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_instr_valid(out_instr_valid), .out_start_pc(out_start_pc),
        .out_pred_taken(out_pred_taken), .out_pred_cut_pos(out_pred_cut_pos),
        .out_pred_target(out_pred_target), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  mask;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_occ    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every decoder handshake must match the oldest expected packet.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", out_start_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pop_pc",     out_start_pc,        e.pc);
                chk("pop_mask",   {28'd0, out_instr_valid}, {28'd0, e.mask});
                chk("pop_instr0", out_instr[0],        e.pc + 32'h100);
                chk("pop_instr3", out_instr[3],        e.pc + 32'h103);
                chk("pop_taken",  {31'd0, out_pred_taken}, {31'd0, e.pc[2]});
                chk("pop_cut",    {30'd0, out_pred_cut_pos}, {30'd0, e.pc[3:2]});
                chk("pop_target", out_pred_target,     e.pc + 32'h10);
            end
        end
    end

    task automatic step(input logic v, input logic [3:0] m, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        bit acc, byp, bcons, popd;
        in_valid        = v;
        in_instr_valid  = m;
        in_start_pc     = pc;
        for (int k = 0; k < FETCH_WIDTH; k++) in_instr[k] = pc + 32'h100 + k;
        in_pred_taken   = pc[2];
        in_pred_cut_pos = pc[3:2];
        in_pred_target  = pc + 32'h10;
        out_ready       = rdy;
        flush           = fl;
        acc = v && (m != 4'd0) && (m_occ < DEPTH) && !fl;
        byp = BYP && (m_occ == 0) && v && (m != 4'd0);
        if (acc) sb.push_back('{pc: pc, mask: m});
        @(negedge clk);
        chk("occupancy", {28'd0, occupancy}, m_occ);
        chk("in_ready",  {31'd0, in_ready}, {31'd0, (m_occ < DEPTH)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ((m_occ > 0) || (byp && !fl))});
        if (m_occ == 0 && !byp) chk("empty_mask", {28'd0, out_instr_valid}, 32'd0);
        bcons = byp && acc && rdy;
        popd  = (m_occ > 0) && rdy && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            m_occ = 0;
            sb.delete();
        end else begin
            m_occ = m_occ + ((acc && !bcons) ? 1 : 0) - (popd ? 1 : 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_instr_valid = 4'd0; in_start_pc = '0; in_instr = '0;
        in_pred_taken = 1'b0; in_pred_cut_pos = '0; in_pred_target = '0;
        out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // First packet after reset, visible next cycle
        step(1, 4'hF, 32'h1C00_0000, 0, 0);
        step(0, 4'h0, 32'h0, 0, 0);
        step(0, 4'h0, 32'h0, 1, 0);
        step(0, 4'h0, 32'h0, 0, 0);

        // Fill to full, ninth push ignored
        for (int i = 0; i < 8; i++) step(1, 4'hF, 32'h1000 + 4*i, 0, 0);
        step(1, 4'hF, 32'h2000, 0, 0);
        // Full with push and pop: pop only, then refill
        step(1, 4'hF, 32'h3000, 1, 0);
        step(1, 4'hF, 32'h3000, 0, 0);
        step(0, 4'h0, 32'h0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 4'h0, 32'h0, 1, 0);

        // Flush with 3 held and a concurrent push
        for (int i = 0; i < 3; i++) step(1, 4'hF, 32'h6000 + 4*i, 0, 0);
        step(1, 4'hF, 32'h6F00, 0, 1);
        step(0, 4'h0, 32'h0, 0, 0);
        step(0, 4'h0, 32'h0, 1, 0);

        // Zero mask dropped, partial mask passed through
        step(1, 4'h0, 32'h7000, 0, 0);
        step(0, 4'h0, 32'h0, 0, 0);
        step(1, 4'h3, 32'h7004, 0, 0);
        step(0, 4'h0, 32'h0, 1, 0);
        step(0, 4'h0, 32'h0, 0, 0);

        // Steady push/pop around occupancy 4 to exercise pointer wrap
        for (int i = 0; i < 4; i++) step(1, 4'hF, 32'h4000 + 4*i, 0, 0);
        for (int i = 4; i < 24; i++) step(1, 4'hF, 32'h4000 + 4*i, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 4'h0, 32'h0, 1, 0);

        // Push into empty buffer with decoder ready
        step(1, 4'hF, 32'h5000, 1, 0);
        step(0, 4'h0, 32'h0, 1, 0);
        step(0, 4'h0, 32'h0, 0, 0);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
